// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: one DVI 1.0 TMDS channel encoder.
// Takes an 8-bit colour component, or a 2-bit control word during blanking,
// and produces one 10-bit DC-balanced symbol per pixel clock.
// Latency is a fixed two clk_pix cycles, with no stalls and no handshake.
// Stage 1 does transition minimisation (q_m). Stage 2 does DC balancing
// against a running disparity count (cnt).
// Optional build macro TMDS_DISPARITY_OUT_EN exposes cnt on port disp_cnt.
module tmds_encoder_dvi (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic [1:0] ctrl_in,
  input  logic       de,
  output logic [9:0] tmds
`ifdef TMDS_DISPARITY_OUT_EN
  ,
  output logic signed [5:0] disp_cnt
`endif
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Stage 1 signals
  logic [3:0] n1_d;
  logic       xnor_mode;
  logic [8:0] qm_d;
  logic       de_s1;
  logic [1:0] ctrl_s1;
  logic [8:0] qm_s1;

  // Stage 2 signals
  logic [3:0]        n1q;
  logic [3:0]        n0q;
  logic signed [5:0] bal;
  logic signed [5:0] qm8_x2;
  logic signed [5:0] nqm8_x2;
  logic signed [5:0] cnt;
  logic signed [5:0] cnt_d;
  logic [9:0]        tmds_d;

  // Transition-minimised word: choose XOR/XNOR chaining from the ones count
  always_comb begin
    n1_d = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, data_in[i]};
    xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_in[0]);
    qm_d      = '0;
    qm_d[0]   = data_in[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = xnor_mode ? ~(qm_d[i-1] ^ data_in[i]) : (qm_d[i-1] ^ data_in[i]);
    qm_d[8] = ~xnor_mode;
  end

  // Stage 1 register: align de/ctrl with the computed q_m
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
      qm_s1   <= '0;
    end else begin
      de_s1   <= de;
      ctrl_s1 <= ctrl_in;
      qm_s1   <= qm_d;
    end
  end

  // DC balance: pick invert/keep from disparity sign, or emit a control symbol
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm_s1[i]};
    n0q     = 4'd8 - n1q;
    bal     = $signed({2'b00, n1q}) - $signed({2'b00, n0q});
    qm8_x2  = $signed({3'b000, qm_s1[8], 1'b0});
    nqm8_x2 = $signed({3'b000, ~qm_s1[8], 1'b0});
    tmds_d  = CTRL_00;
    cnt_d   = '0;
    if (!de_s1) begin
      // Blanking: disparity restarts so the next video run begins balanced
      case (ctrl_s1)
        2'b00:   tmds_d = CTRL_00;
        2'b01:   tmds_d = CTRL_01;
        2'b10:   tmds_d = CTRL_10;
        default: tmds_d = CTRL_11;
      endcase
      cnt_d = '0;
    end else if ((cnt == 6'sd0) || (n1q == n0q)) begin
      tmds_d = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
      cnt_d  = qm_s1[8] ? (cnt + bal) : (cnt - bal);
    end else if ((!cnt[5] && (n1q > n0q)) || (cnt[5] && (n0q > n1q))) begin
      tmds_d = {1'b1, qm_s1[8], ~qm_s1[7:0]};
      cnt_d  = cnt + qm8_x2 - bal;
    end else begin
      tmds_d = {1'b0, qm_s1[8], qm_s1[7:0]};
      cnt_d  = cnt + bal - nqm8_x2;
    end
  end

  // Stage 2 register: output symbol and running disparity
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      tmds <= CTRL_00;
      cnt  <= '0;
    end else begin
      tmds <= tmds_d;
      cnt  <= cnt_d;
    end
  end

`ifdef TMDS_DISPARITY_OUT_EN
  assign disp_cnt = cnt;
`else
  // Disparity count stays internal in this build.
`endif

endmodule

// File: doc/tmds_encoder_dvi.md
Name: tmds_encoder_dvi

Overview:
Per-channel DVI 1.0 TMDS encoder. Converts one 8-bit colour component, or a 2-bit control word during blanking, into a 10-bit DC-balanced TMDS symbol every pixel clock.
Sits between the pixel/colour generation logic (red/green/blue, de, hsync/vsync) and the 10:1 serialiser. Three instances are used, one per channel.
Two-stage pipeline with a running-disparity accumulator.

Parameters:
- None. Widths are fixed by DVI 1.0: 8-bit data, 2-bit control, 10-bit symbol.

Ports:
- clk_pix  in  1  pixel clock; all logic in this domain
- rst  in  1  asynchronous, active-high reset
- data_in  in  8  colour component; valid when de=1
- ctrl_in  in  2  control bits {C1,C0}; used when de=0
- de  in  1  data enable: 1 = video period, 0 = control period
- tmds  out  10  encoded symbol, bit 0 transmitted first

Behaviour:
- Reset (async assert, sync release to clk_pix):
  - tmds = 10'b1101010100 (control 00 symbol)
  - pipeline de = 0, ctrl = 00
  - disparity cnt = 0
- Latency: fixed 2 clk_pix cycles from inputs to tmds in both video and control periods. No stalls, no handshake; one symbol per cycle.
- Stage 1 (registered): capture de and ctrl; compute q_m[8:0] from data_in.
  - N1 = number of ones in data_in.
  - Mode: XNOR if N1>4, or if N1==4 and data_in[0]==0; otherwise XOR.
  - q_m[0] = D[0]; q_m[i] = q_m[i-1] XOR/XNOR D[i] for i=1..7.
  - q_m[8] = 1 for XOR mode, 0 for XNOR mode.
- Stage 2 (registered): DC balance.
  - N1q/N0q = counts of ones/zeros in q_m[7:0].
  - cnt is a 6-bit signed register, always even, range -8..+8 in legal operation.
  - Case A, cnt==0 or N1q==N0q:
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q)
  - Case B, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - tmds = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + (N0q-N1q)
  - Case C, otherwise:
    - tmds = {0, q_m[8], q_m[7:0]}
    - cnt += (N1q-N0q) - 2*(~q_m[8])
- Control period (stage-2 de=0):
  - tmds from ctrl: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - cnt forced to 0 every control cycle.
- de transitions:
  - The first video symbol after blanking always starts with cnt=0.
  - The last video symbol is followed by a control symbol exactly 2 cycles after de falls at the input.
  - No partial or merged symbols at either boundary.
- Arithmetic: counts are 4-bit unsigned, zero-extended before signed add. cnt saturation is not required. Wrap cannot occur for legal inputs.
- Reset mid-operation: tmds and cnt return to reset values immediately. Symbols in flight are discarded.
- data_in is ignored when de=0; ctrl_in is ignored when de=1.

Optional Feature:
- Macro: TMDS_DISPARITY_OUT_EN
- Defined: adds output port disp_cnt (out, 6, signed), which equals the stage-2 cnt register (post-update, aligned with tmds). Reset value 0. Used for verification and debug probing.
- Undefined: port absent; cnt remains internal; encoding behaviour identical.

Test Plan:
- Reset/control: rst=1, then release with de=0 and ctrl_in cycling 00,01,10,11. tmds = 1101010100, 0010101011, 0101010100, 1010101011, each 2 cycles after input; cnt stays 0.
- Zero data from balanced start: one blanking cycle, then de=1 with data_in=0x00 held. tmds sequence = 0x100, 0x3FF, 0x100, 0x3FF, ... disp_cnt = -8, 2, -6, 4, -4, 6, -2, 8, 0, then repeats.
- All-ones data: after blanking, data_in=0xFF for one cycle → XNOR mode, q_m=0x0FF, tmds=0x200, disp_cnt=-8. Then de=0 → next symbol is the control symbol and disp_cnt=0.
- de boundary: 0x00 for 3 cycles, de=0 for 1 cycle, 0x00 again. Output: 0x100, 0x3FF, 0x100, control symbol, 0x100 (cnt restarted at 0, not continuing at -6).
- Async reset mid-stream: assert rst between clock edges during video. tmds = 1101010100 and disp_cnt=0 before the next clk_pix edge. After release, 0x00 input first produces 0x100 again.
- Random compare: 10,000 cycles of random data_in/de/ctrl_in against a reference-model encoder. Zero mismatches, and |disp_cnt| ≤ 8 throughout.
